// File: rtl/conv_mac_accum.sv
// Window accumulator behind the pipelined multiplier: sums TAPS signed products,
// adds bias, rescales, optional ReLU, saturates and hands the activation downstream.
module conv_mac_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int TAPS   = 9,
  parameter int SHIFT  = 4,
  parameter bit RELU   = 1'b1
) (
  input  logic                       clock,
  input  logic                       aclr_n,
  input  logic                       clken,
  input  logic                       flush,
  input  logic                       prod_valid,
  input  logic signed [PROD_W-1:0]   product,
  output logic                       prod_ready,
  input  logic signed [OUT_W-1:0]    bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    result,
  output logic                       sat,
  output logic [$clog2(TAPS)-1:0]    tap_cnt
);

  localparam int CNT_W = $clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] result_q, result_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] scaled;
  logic                    last_tap;
  logic                    accept;
  logic [OUT_W:0]          fin;

  function automatic logic signed [ACC_W-1:0] relu_fn(input logic signed [ACC_W-1:0] v);
    if (RELU && v < 0) return '0;
    return v;
  endfunction

  // Packs {saturated, value}.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] v);
    if (v > OUT_MAX) return {1'b1, OUT_MAX[OUT_W-1:0]};
    if (v < OUT_MIN) return {1'b1, OUT_MIN[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  assign prod_ext   = ACC_W'(product);
  assign bias_ext   = ACC_W'(bias);
  assign last_tap   = (tap_cnt_q == LAST_TAP);
  // Stall only when completing would clobber a result nobody has taken yet.
  assign prod_ready = !(last_tap && out_valid_q && !out_ready);
  assign accept     = prod_valid && prod_ready && clken;

  assign sum    = acc_q + prod_ext + bias_ext;
  assign scaled = relu_fn(sum >>> SHIFT);
  assign fin    = sat_fn(scaled);

  always_comb begin
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    if (clken) begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (flush) begin
        tap_cnt_d = '0;
      end else if (accept) begin
        if (last_tap) begin
          result_d    = fin[OUT_W-1:0];
          sat_d       = fin[OUT_W];
          out_valid_d = 1'b1;
          tap_cnt_d   = '0;
        end else begin
          acc_d     = (tap_cnt_q == '0) ? prod_ext : acc_q + prod_ext;
          tap_cnt_d = tap_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Result register stage
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat       = sat_q;
  assign tap_cnt   = tap_cnt_q;

endmodule

// File: tb/tb_conv_mac_accum.sv
// Scoreboard bench for conv_mac_accum: one ReLU and one linear instance share stimulus.
module tb_conv_mac_accum;

  logic clk;
  logic aclr_n;
  logic clken;
  logic flush;
  logic prod_valid;
  logic signed [15:0] product;
  logic signed [7:0]  bias;
  logic out_ready;

  logic prod_ready, prod_ready_l;
  logic out_valid, out_valid_l;
  logic signed [7:0] result, result_l;
  logic sat, sat_l;
  logic [3:0] tap_cnt, tap_cnt_l;

  typedef struct {
    logic signed [7:0] ra;
    logic              sa;
    logic signed [7:0] rl;
    logic              sl;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  conv_mac_accum #(.RELU(1'b1)) u_dut_relu (
    .clock(clk), .aclr_n(aclr_n), .clken(clken), .flush(flush),
    .prod_valid(prod_valid), .product(product), .prod_ready(prod_ready),
    .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat), .tap_cnt(tap_cnt)
  );

  conv_mac_accum #(.RELU(1'b0)) u_dut_lin (
    .clock(clk), .aclr_n(aclr_n), .clken(clken), .flush(flush),
    .prod_valid(prod_valid), .product(product), .prod_ready(prod_ready_l),
    .bias(bias), .out_valid(out_valid_l), .out_ready(out_ready),
    .result(result_l), .sat(sat_l), .tap_cnt(tap_cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic void sat8(input int s, output logic signed [7:0] r, output logic f);
    if (s > 127) begin r = 8'sd127; f = 1'b1; end
    else if (s < -128) begin r = -8'sd128; f = 1'b1; end
    else begin r = 8'(s); f = 1'b0; end
  endfunction

  // Reference: nine equal products plus bias, floor-divided by 16.
  function automatic exp_t model(input int val, input int b);
    exp_t e;
    int sum, s, sr;
    sum = 9 * val + b;
    s = sum >>> 4;
    sr = (s < 0) ? 0 : s;
    sat8(sr, e.ra, e.sa);
    sat8(s, e.rl, e.sl);
    return e;
  endfunction

  // Present one product until the stage takes it; ends at posedge+1.
  task automatic tap(input logic signed [15:0] p);
    int n;
    n = 0;
    prod_valid = 1'b1;
    product = p;
    @(negedge clk);
    while (!(prod_ready && clken)) begin
      n++;
      if (n > 200) begin
        chk("tap_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
  endtask

  task automatic send_window(input int val, input int b, input int first, input bit gaps);
    for (int i = first; i < 9; i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      bias = (i == 8) ? 8'(b) : 8'($urandom);
      tap(16'(val));
    end
    sbq.push_back(model(val, b));
  endtask

  always @(negedge clk) begin
    if (aclr_n && clken && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("res_relu", result, e.ra);
        chk("sat_relu", sat, e.sa);
        chk("res_lin", result_l, e.rl);
        chk("sat_lin", sat_l, e.sl);
        chk("valid_lin", out_valid_l, 1);
      end
    end
  end

  initial begin
    aclr_n = 1'b0; clken = 1'b1; flush = 1'b0; prod_valid = 1'b0;
    product = '0; bias = '0; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sat", sat, 0);
    chk("rst_tap", tap_cnt, 0);
    chk("rst_ready", prod_ready, 1);
    @(posedge clk); #1;
    aclr_n = 1'b1;

    // Basic window: single-cycle valid pulse, then back-to-back windows
    send_window(16, 0, 0, 0);
    chk("pulse_hi", out_valid, 1);
    @(posedge clk); #1;
    chk("pulse_lo", out_valid, 0);
    send_window(16, 5, 0, 0);
    send_window(1000, 0, 0, 0);
    send_window(-1000, 0, 0, 0);
    send_window(-32, 0, 0, 0);
    send_window(-32, 100, 0, 1);

    // Backpressure: completing tap stalls behind a held result
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_window(16, 0, 0, 0);
    for (int i = 0; i < 8; i++) tap(16);
    prod_valid = 1'b1; product = 16; bias = 0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", prod_ready, 0);
      chk("bp_tap", tap_cnt, 8);
      chk("bp_hold", result, 9);
      chk("bp_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", prod_ready, 1);
    sbq.push_back(model(16, 0));
    @(posedge clk); #1;
    prod_valid = 1'b0;
    chk("bp_valid_cont", out_valid, 1);
    chk("bp_tap_wrap", tap_cnt, 0);
    @(posedge clk); #1;

    // Flush discards a partial window, including a same-cycle product
    for (int i = 0; i < 4; i++) tap(100);
    flush = 1'b1; prod_valid = 1'b1; product = 100;
    @(posedge clk); #1;
    flush = 1'b0; prod_valid = 1'b0;
    chk("flush_tap", tap_cnt, 0);
    send_window(16, 0, 0, 1);

    // Clock enable low freezes the partial window
    for (int i = 0; i < 4; i++) tap(16);
    clken = 1'b0; prod_valid = 1'b1; product = 1000; flush = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("clken_tap", tap_cnt, 4);
    end
    clken = 1'b1; flush = 1'b0; prod_valid = 1'b0;
    send_window(16, 0, 4, 0);

    // Asynchronous reset mid-window with a result pending
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_window(16, 0, 0, 0);
    for (int i = 0; i < 5; i++) tap(16);
    chk("pre_rst_tap", tap_cnt, 5);
    #2;
    aclr_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_tap", tap_cnt, 0);
    sbq.delete();
    @(posedge clk); #1;
    aclr_n = 1'b1;
    out_ready = 1'b1;
    send_window(16, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_mac_accum.md
# conv_mac_accum

Accumulation stage placed directly downstream of the pipelined `lpm_mult` multiplier in the convolution datapath. It consumes one signed product per cycle and sums TAPS products (one kernel window). It then adds a per-channel bias, rescales by an arithmetic right shift, applies optional ReLU and saturates. The finished activation is presented to the next layer over a valid/ready handshake.

## Interface
- PROD_W, 16: width of signed product from multiplier (lpm_widthp)
- ACC_W, 24: accumulator width, signed; ≥ PROD_W + ceil(log2(TAPS+1))
- OUT_W, 8: width of signed output activation
- TAPS, 9: products per window (≥ 2)
- SHIFT, 4: arithmetic right-shift applied to final sum (0..ACC_W-1)
- RELU, 1: 1 = clamp negative results to 0

- clock  in  1  rising-edge clock
- aclr_n  in  1  asynchronous reset, active-low
- clken  in  1  clock enable; low freezes all state, outputs hold
- flush  in  1  synchronous abort of current partial window
- prod_valid  in  1  product is valid this cycle
- product  in  PROD_W  signed product
- prod_ready  out  1  stage accepts product this cycle
- bias  in  OUT_W  signed bias, sampled with the last tap of a window
- out_valid  out  1  result register holds a finished activation
- out_ready  in  1  downstream accepts result
- result  out  OUT_W  signed activation
- sat  out  1  result was saturated (qualified by out_valid)
- tap_cnt  out  ceil(log2 TAPS)  index of the next tap expected

## Operation
- Reset is asynchronous on aclr_n low. acc=0, tap_cnt=0, out_valid=0, result=0, sat=0. The window is discarded.
- All sequential updates require clken=1. flush, the handshakes and accumulation are ignored while clken=0.
- Accept: prod_valid & prod_ready & clken.
- prod_ready = !(tap_cnt==TAPS-1 && out_valid && !out_ready). The stage stalls only when the completing tap would overwrite an unconsumed result.
- Accept with tap_cnt<TAPS-1: acc <= acc + sext(product) and tap_cnt++. When tap_cnt==0 the new product loads in place of the old acc (acc <= sext(product)).
- Accept with tap_cnt==TAPS-1:
  - sum = acc + sext(product) + sext(bias), taken modulo 2^ACC_W.
  - s = sum >>> SHIFT.
  - If RELU and s<0, then s=0.
  - Saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - result <= saturated value, sat <= (saturation occurred), out_valid <= 1, tap_cnt <= 0.
- Output drain: out_valid & out_ready & clken clears out_valid. A completion in the same cycle overrides the clear, so out_valid stays 1 and the new result is loaded.
- flush (with clken):
  - tap_cnt <= 0. Any product accepted in the same cycle is discarded.
  - out_valid, result and sat are unaffected.
- A non-accepted cycle (prod_valid=0 or stalled) leaves acc and tap_cnt unchanged, so gaps in the product stream are allowed.

## Timing
- Throughput is 1 product/cycle when unstalled.
- Latency: result is visible and out_valid=1 on the cycle after the clock edge that accepted the last tap (1 register stage).
- result and sat are held stable while out_valid=1 and out_ready=0.
- prod_ready is combinational from tap_cnt, out_valid and out_ready. There is no path from prod_valid to prod_ready.
- bias is sampled only on the completing tap's edge.

## Test plan
- Basic window, defaults: 9× product=16, bias=0, out_ready=1 -> out_valid=1 for 1 cycle, result=9 (144>>>4), sat=0. Then back-to-back with bias=5 -> result=9 (149>>>4=9).
- Saturation: 9× product=1000, bias=0 -> result=127, sat=1. RELU=0 with 9× product=-1000 -> result=-128, sat=1.
- ReLU: 9× product=-32, bias=0 -> RELU=1 gives result=0, sat=0. RELU=0 gives result=-18.
- Backpressure:
  - Setup: out_ready=0, two windows of 9× product=16, bias=0.
  - First result is held at 9.
  - prod_ready=0 only while tap_cnt==8. tap_cnt stays at 8 while stalled.
  - Raising out_ready drains the first result and accepts the stalled tap in the same cycle. The second result=9 appears the next cycle with out_valid continuously high.
- Flush and gaps:
  - 4 products of 100, flush, then 9 products of 16 with random prod_valid gaps -> result=9. The flushed taps must not contribute.
  - clken=0 for 3 cycles mid-window -> no state change.
- Reset mid-window: aclr_n low asynchronously after 5 taps, with result pending. Immediately out_valid=0, result=0, tap_cnt=0. After release, a fresh 9-tap window gives the correct result=9.
